// File: rtl/bus_snoop_responder.sv
// rtl/bus_snoop_responder.sv - snoop-window bus responder with owner-flush and memory phases
module bus_snoop_responder #(
    parameter int SNOOP_WIN = 2,
    parameter int MEM_LAT   = 4
) (
    input  logic        clk,
    input  logic        rstb,
    input  logic        req_valid,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_addr,
    output logic        req_ready,
    input  logic        snp_hit,
    input  logic        snp_hitm,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        flush_busy,
    output logic        resp_valid,
    output logic        resp_shared,
    output logic [1:0]  resp_op,
    output logic [31:0] resp_addr,
    output logic [15:0] hitm_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SNOOP,
        S_FLUSH,
        S_MEM,
        S_DONE
    } state_t;

    localparam logic [1:0] OP_RD    = 2'd0;
    localparam logic [1:0] OP_UPGR  = 2'd2;
    localparam logic [1:0] OP_FLUSH = 2'd3;

    localparam logic [7:0] SNOOP_LOAD = 8'(SNOOP_WIN - 1);
    localparam logic [7:0] MEM_LOAD   = 8'(MEM_LAT - 1);

    state_t      state;
    state_t      next_state;
    logic [1:0]  op_q;
    logic [31:0] addr_q;
    logic        hit_acc;
    logic        hitm_acc;
    logic [7:0]  cnt;
    logic        cnt_last;
    logic        hitm_final;

    assign cnt_last   = (cnt == 8'd0);
    // the HITM decision must see the snoop input on the last window edge too
    assign hitm_final = hitm_acc | snp_hitm;

    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        flush_busy = 1'b0;
        resp_valid = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) next_state = S_SNOOP;
            end
            S_SNOOP: begin
                if (cnt_last) begin
                    if (op_q == OP_UPGR)       next_state = S_DONE;
                    else if (op_q == OP_FLUSH) next_state = S_MEM;
                    else if (hitm_final)       next_state = S_FLUSH;
                    else                       next_state = S_MEM;
                end
            end
            S_FLUSH: begin
                flush_busy = 1'b1;
                if (cnt_last) next_state = S_DONE;
            end
            S_MEM: begin
                mem_wr = (op_q == OP_FLUSH);
                mem_rd = (op_q != OP_FLUSH);
                if (cnt_last) next_state = S_DONE;
            end
            S_DONE: begin
                resp_valid = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state       <= S_IDLE;
            op_q        <= 2'd0;
            addr_q      <= 32'h0;
            hit_acc     <= 1'b0;
            hitm_acc    <= 1'b0;
            cnt         <= 8'd0;
            resp_shared <= 1'b0;
            resp_op     <= 2'd0;
            resp_addr   <= 32'h0;
            hitm_cnt    <= 16'h0;
        end else begin
            state <= next_state;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        op_q     <= req_op;
                        addr_q   <= req_addr;
                        hit_acc  <= 1'b0;
                        hitm_acc <= 1'b0;
                        cnt      <= SNOOP_LOAD;
                    end
                end
                S_SNOOP: begin
                    hit_acc  <= hit_acc | snp_hit;
                    hitm_acc <= hitm_acc | snp_hitm;
                    // reload on the way out so FLUSH/MEM start with a full latency count
                    cnt      <= cnt_last ? MEM_LOAD : cnt - 8'd1;
                end
                S_FLUSH, S_MEM: begin
                    if (!cnt_last) cnt <= cnt - 8'd1;
                end
                default: ;
            endcase
            if (state == S_SNOOP && next_state == S_FLUSH && hitm_cnt != 16'hFFFF)
                hitm_cnt <= hitm_cnt + 16'd1;
            // response fields are registered on DONE entry and held until the next DONE
            if (state != S_DONE && next_state == S_DONE) begin
                resp_shared <= (op_q == OP_RD) & (hit_acc | hitm_acc);
                resp_op     <= op_q;
                resp_addr   <= addr_q;
            end
        end
    end

endmodule

// File: tb/tb_bus_snoop_responder.sv
// tb/tb_bus_snoop_responder.sv - self-checking bench for bus_snoop_responder
module tb_bus_snoop_responder;

    localparam int W = 2;
    localparam int L = 4;

    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic        req_valid = 1'b0;
    logic [1:0]  req_op = 2'd0;
    logic [31:0] req_addr = 32'h0;
    logic        req_ready;
    logic        snp_hit = 1'b0;
    logic        snp_hitm = 1'b0;
    logic        mem_rd;
    logic        mem_wr;
    logic        flush_busy;
    logic        resp_valid;
    logic        resp_shared;
    logic [1:0]  resp_op;
    logic [31:0] resp_addr;
    logic [15:0] hitm_cnt;

    int          n_assert = 0;
    int          n_fail = 0;
    int          exp_hitm_cnt = 0;

    bus_snoop_responder #(.SNOOP_WIN(W), .MEM_LAT(L)) dut (
        .clk(clk), .rstb(rstb), .req_valid(req_valid), .req_op(req_op),
        .req_addr(req_addr), .req_ready(req_ready), .snp_hit(snp_hit),
        .snp_hitm(snp_hitm), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .flush_busy(flush_busy), .resp_valid(resp_valid),
        .resp_shared(resp_shared), .resp_op(resp_op), .resp_addr(resp_addr),
        .hitm_cnt(hitm_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, req_ready, 1);
        check({tag, "_mem_rd"}, mem_rd, 0);
        check({tag, "_mem_wr"}, mem_wr, 0);
        check({tag, "_flush_busy"}, flush_busy, 0);
        check({tag, "_resp_valid"}, resp_valid, 0);
        check({tag, "_resp_shared"}, resp_shared, 0);
        check({tag, "_resp_op"}, resp_op, 0);
        check({tag, "_resp_addr"}, resp_addr, 0);
        check({tag, "_hitm_cnt"}, hitm_cnt, 0);
    endtask

    // One transaction, starting in an IDLE cycle. noise: 0 quiet, 1 random
    // req/snoop traffic outside the window, 2 req_valid held high throughout.
    task automatic txn(input logic [1:0] op, input logic [31:0] addr,
                       input logic [7:0] hmask, input logic [7:0] mmask, input int noise);
        bit hit = 0;
        bit hitm = 0;
        bit fl, mem;
        int lat;
        bit in_mem;
        for (int i = 0; i < W; i++) begin
            hit  |= hmask[i];
            hitm |= mmask[i];
        end
        fl  = hitm && (op == 2'd0 || op == 2'd1);
        mem = (op != 2'd2) && !fl;
        lat = (op == 2'd2) ? 1 + W : 1 + W + L;

        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        @(negedge clk);
        check("ready_idle", req_ready, 1);
        @(posedge clk);
        #1;
        for (int c = 1; c <= lat; c++) begin
            if (noise == 2)      req_valid = 1'b1;
            else if (noise == 1) req_valid = 1'($urandom_range(0, 1));
            else                 req_valid = 1'b0;
            if (noise != 0) begin
                req_op   = 2'($urandom_range(0, 3));
                req_addr = $urandom;
            end
            if (c <= W) begin
                snp_hit  = hmask[c-1];
                snp_hitm = mmask[c-1];
            end else if (noise != 0) begin
                snp_hit  = 1'($urandom_range(0, 1));
                snp_hitm = 1'($urandom_range(0, 1));
            end else begin
                snp_hit  = 1'b0;
                snp_hitm = 1'b0;
            end
            @(negedge clk);
            in_mem = (op != 2'd2) && (c > W) && (c <= W + L);
            check("ready_busy", req_ready, 0);
            check("mem_rd", mem_rd, in_mem && mem && op != 2'd3);
            check("mem_wr", mem_wr, in_mem && mem && op == 2'd3);
            check("flush_busy", flush_busy, in_mem && fl);
            check("resp_valid", resp_valid, c == lat);
            if (c == lat) begin
                check("resp_shared", resp_shared, (op == 2'd0) && (hit || hitm));
                check("resp_op", resp_op, op);
                check("resp_addr", resp_addr, addr);
            end
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        snp_hit   = 1'b0;
        snp_hitm  = 1'b0;
        if (fl && exp_hitm_cnt < 16'hFFFF) exp_hitm_cnt++;
        check("hitm_cnt", hitm_cnt, exp_hitm_cnt);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rstb = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        rstb = 1'b1;

        txn(2'd0, 32'h0000_1040, 8'b00, 8'b00, 0);
        txn(2'd0, 32'h0000_2080, 8'b10, 8'b00, 0);
        txn(2'd1, 32'h0000_30C0, 8'b00, 8'b01, 0);
        txn(2'd2, 32'h0000_4100, 8'b11, 8'b11, 2);
        txn(2'd0, 32'h0000_5140, 8'b01, 8'b00, 0);
        txn(2'd3, 32'h0000_6180, 8'b01, 8'b11, 0);
        txn(2'd1, 32'hDEAD_BEC0, 8'b11, 8'b00, 1);
        txn(2'd0, 32'hCAFE_0000, 8'b00, 8'b10, 1);

        for (int k = 0; k < 24; k++) begin
            txn(2'($urandom_range(0, 3)), $urandom,
                8'($urandom_range(0, 3)), 8'($urandom_range(0, 3) & $urandom_range(0, 3)),
                int'($urandom_range(0, 2)));
        end

        // Reset abort: BusRd sees HITM, reset lands in the fourth cycle (FLUSH)
        req_valid = 1'b1;
        req_op    = 2'd0;
        req_addr  = 32'h0000_7000;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        snp_hitm  = 1'b1;
        @(posedge clk);
        #1;
        snp_hitm = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("abort_flush_busy", flush_busy, 1);
        check("abort_hitm_pre", hitm_cnt, exp_hitm_cnt + 1 > 16'hFFFF ? 16'hFFFF : exp_hitm_cnt + 1);
        rstb = 1'b0;
        #1;
        check_reset_outputs("abort");
        repeat (2) begin
            @(negedge clk);
            check("abort_hold_resp_valid", resp_valid, 0);
        end
        @(posedge clk);
        #1;
        rstb = 1'b1;
        exp_hitm_cnt = 0;
        repeat (8) begin
            @(negedge clk);
            check("post_reset_no_resp", resp_valid, 0);
            check("post_reset_ready", req_ready, 1);
        end
        @(posedge clk);
        #1;
        txn(2'd0, 32'h0000_8040, 8'b01, 8'b00, 0);
        txn(2'd1, 32'h0000_90C0, 8'b00, 8'b10, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_snoop_responder.md
BUS_SNOOP_RESPONDER -- requirements
Module: bus_snoop_responder

Interface
REQ-001 Parameter SNOOP_WIN, default 2: snoop window length in cycles; legal range 1-255.
REQ-002 Parameter MEM_LAT, default 4: memory or owner-flush latency in cycles; legal range 1-255.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 Port rstb, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port req_valid, input, 1 bit: the cache presents a bus operation.
REQ-006 Port req_op, input, 2 bits: bus operation.
- 0 = BusRd.
- 1 = BusRdX.
- 2 = BusUpgr.
- 3 = Flush (write-back).
REQ-007 Port req_addr, input, 32 bits: line address of the operation.
REQ-008 Port req_ready, output, 1 bit: the block accepts a request this cycle.
REQ-009 Port snp_hit, input, 1 bit: another agent holds the line in S or E.
REQ-010 Port snp_hitm, input, 1 bit: another agent holds the line in M.
REQ-011 Port mem_rd and port mem_wr, outputs, 1 bit each: memory read or write in progress.
REQ-012 Port flush_busy, output, 1 bit: the owning agent is flushing the line.
REQ-013 Port resp_valid, output, 1 bit: one-cycle completion pulse.
REQ-014 Port resp_shared, output, 1 bit: C_in value returned to the cache.
REQ-015 Port resp_op, output, 2 bits: echo of the captured operation.
REQ-016 Port resp_addr, output, 32 bits: echo of the captured address.
REQ-017 Port hitm_cnt, output, 16 bits: count of transactions that saw HITM.

Function
REQ-018 The state machine SHALL have the states IDLE, SNOOP, FLUSH, MEM and DONE.
REQ-019 req_ready SHALL equal (state==IDLE); a request SHALL transfer on a rising edge with req_valid and req_ready both 1.
REQ-020 On transfer, the block SHALL capture req_op and req_addr, clear the hit/hitm accumulators and the counter, and go to SNOOP.
REQ-021 req_valid while not in IDLE SHALL be ignored; no state or capture change, and no queueing.
REQ-022 SNOOP SHALL last exactly SNOOP_WIN cycles; on each edge in SNOOP, hit_acc |= snp_hit and hitm_acc |= snp_hitm.
REQ-023 Leaving SNOOP, the next state SHALL depend on the operation and the accumulated result:
- BusUpgr: DONE.
- Flush: MEM with mem_wr=1.
- BusRd or BusRdX with the final hitm_acc=1: FLUSH.
- Otherwise: MEM with mem_rd=1.
- The final hitm_acc includes the last SNOOP edge.
REQ-024 FLUSH and MEM SHALL each last exactly MEM_LAT cycles and then go to DONE.
REQ-025 In FLUSH, flush_busy=1. In MEM, mem_rd or mem_wr is held high throughout, never both.
REQ-026 DONE SHALL last one cycle, with resp_valid=1 and resp_op/resp_addr equal to the captured values; the next state is IDLE.
REQ-027 resp_shared SHALL be (hit_acc|hitm_acc) for BusRd, and 0 for BusRdX, BusUpgr and Flush.
REQ-028 resp_shared, resp_op and resp_addr SHALL hold their values until the next DONE; they are valid only while resp_valid=1.
REQ-029 Latency from the accept edge to resp_valid SHALL be:
- 1+SNOOP_WIN+MEM_LAT cycles for BusRd, BusRdX and Flush.
- 1+SNOOP_WIN cycles for BusUpgr.
REQ-030 The earliest next accept SHALL be on the edge after DONE.
REQ-031 hitm_cnt SHALL increment by 1 on each entry to FLUSH and saturate at 16'hFFFF.
REQ-032 snp_hit and snp_hitm SHALL be ignored outside SNOOP.
REQ-033 snp_hitm=1 for a Flush or BusUpgr operation SHALL NOT enter FLUSH and SHALL NOT increment hitm_cnt.
REQ-034 The phase counter SHALL be 8 bits wide; it is loaded at each phase entry and decremented to terminal, with no wrap-around.

Reset
REQ-035 While rstb=0, the block SHALL asynchronously force:
- state to IDLE.
- req_ready to 1.
- mem_rd, mem_wr, flush_busy, resp_valid and resp_shared to 0.
- resp_op to 0 and resp_addr to 32'h0.
- hitm_cnt, the accumulators and the counter to 0.
REQ-036 Reset asserted mid-transaction SHALL abort it with no resp_valid.
REQ-037 After rstb deasserts, the first accept SHALL be possible on the first rising edge.

Verification (SNOOP_WIN=2, MEM_LAT=4)
REQ-038 BusRd of 32'h0000_1040 accepted at edge 0 with no snoop inputs:
- mem_rd=1 in cycles 3-6.
- resp_valid=1 in cycle 7 with resp_shared=0 and resp_addr=32'h0000_1040.
- req_ready=1 in cycle 8.
REQ-039 BusRd with snp_hit=1 in cycle 2 only:
- resp_shared=1 in cycle 7.
- hitm_cnt stays 0.
REQ-040 BusRdX with snp_hitm=1 in cycle 1:
- flush_busy=1 in cycles 3-6 and mem_rd stays 0.
- resp_valid in cycle 7 with resp_shared=0.
- hitm_cnt=1.
REQ-041 BusUpgr:
- resp_valid in cycle 3 with no mem_rd or mem_wr.
- A second req_valid held through cycles 1-3 is accepted at edge 4, not earlier.
REQ-042 Flush: mem_wr=1 in cycles 3-6; snp_hitm=1 during SNOOP gives no FLUSH state and no count.
REQ-043 BusRd with snp_hitm, and rstb pulsed low in cycle 4:
- Outputs read reset values immediately.
- No resp_valid occurs.
- hitm_cnt=0.
- A new BusRd completes normally afterwards.
